// File: rtl/uart_report_time.sv
// Purpose: serialises a 19-byte "YY-MM-DD HH:MM:SS\r\n" time report onto an 8N1 UART line.
// Latency: request in cycle N -> start bit on uart_tx in cycle N+1; report lasts 190*BAUD_DIV cycles.
// Backpressure: requests while busy fold into one pending flag; that report starts the cycle after done.
// Ports: clk/rst (sync, active-high); time_now/date_now BCD inputs; report_req/auto_en request sources;
//        uart_tx serial line (idle high); busy covers the whole report; done pulses once after the last stop bit.
module uart_report_time #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] time_now,
    input  logic [31:0] date_now,
    input  logic        report_req,
    input  logic        auto_en,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [4:0]       LAST_BYTE = 5'd18;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // BCD digit to ASCII; anything that is not a decimal digit shows as '?'.
    function automatic logic [7:0] nib_ascii(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : {4'h3, n};
    endfunction

    // Character at position idx of the report; d holds {year, month, day}.
    function automatic logic [7:0] report_char(input logic [4:0]  idx,
                                               input logic [23:0] t,
                                               input logic [23:0] d);
        logic [7:0] c;
        case (idx)
            5'd0:    c = nib_ascii(d[23:20]);
            5'd1:    c = nib_ascii(d[19:16]);
            5'd2:    c = 8'h2D;
            5'd3:    c = nib_ascii(d[15:12]);
            5'd4:    c = nib_ascii(d[11:8]);
            5'd5:    c = 8'h2D;
            5'd6:    c = nib_ascii(d[7:4]);
            5'd7:    c = nib_ascii(d[3:0]);
            5'd8:    c = 8'h20;
            5'd9:    c = nib_ascii(t[23:20]);
            5'd10:   c = nib_ascii(t[19:16]);
            5'd11:   c = 8'h3A;
            5'd12:   c = nib_ascii(t[15:12]);
            5'd13:   c = nib_ascii(t[11:8]);
            5'd14:   c = 8'h3A;
            5'd15:   c = nib_ascii(t[7:4]);
            5'd16:   c = nib_ascii(t[3:0]);
            5'd17:   c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [4:0]       byte_q, byte_d;
    logic             pending_q, pending_d;
    logic [7:0]       prev_sec_q, prev_sec_d;
    logic [23:0]      snap_time_q, snap_time_d;
    logic [23:0]      snap_date_q, snap_date_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             req;
    logic             bit_end;
    logic [2:0]       bit_nx;
    logic [7:0]       cur_byte;

    // The weekday field is not part of the report.
    logic unused_weekday;
    assign unused_weekday = ^date_now[7:0];

    assign req      = report_req | (auto_en & (time_now[7:0] != prev_sec_q));
    assign bit_end  = (baud_q == CNT_LAST);
    assign bit_nx   = bit_q + 3'd1;
    assign cur_byte = report_char(byte_q, snap_time_q, snap_date_q);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        pending_d   = pending_q;
        snap_time_d = snap_time_q;
        snap_date_d = snap_date_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        // Tracked every cycle so that raising auto_en never sees a stale second.
        prev_sec_d  = time_now[7:0];

        // Outside IDLE a request can only be remembered; repeats merge into one.
        if (state_q != IDLE && req) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Also covers the done cycle, so a request there is never lost.
                if (req || pending_q) begin
                    state_d     = START;
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                    baud_d      = '0;
                    bit_d       = '0;
                    byte_d      = '0;
                    pending_d   = 1'b0;
                    snap_time_d = time_now;
                    snap_date_d = date_now[31:8];
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nx;
                        tx_d  = cur_byte[bit_nx];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_q < LAST_BYTE) begin
                        byte_d  = byte_q + 5'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        byte_d  = '0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            pending_q   <= 1'b0;
            prev_sec_q  <= time_now[7:0];
            snap_time_q <= '0;
            snap_date_q <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            pending_q   <= pending_d;
            prev_sec_q  <= prev_sec_d;
            snap_time_q <= snap_time_d;
            snap_date_q <= snap_date_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/uart_report_time.md
UART_REPORT_TIME -- requirements
Module: uart_report_time

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer division, >= 2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port time_now  input  24  current time, BCD: [23:16] hour, [15:8] minute, [7:0] second.
REQ-006 SHALL have port date_now  input  32  current date, BCD: [31:24] year, [23:16] month, [15:8] day, [7:0] weekday (not transmitted).
REQ-007 SHALL have port report_req  input  1  one-cycle request to transmit one report.
REQ-008 SHALL have port auto_en  input  1  when high, a report is requested on every change of time_now[7:0].
REQ-009 SHALL have port uart_tx  output  1  serial line, 8N1, idle high.
REQ-010 SHALL have port busy  output  1  high from frame start through the last stop bit.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last stop bit of a report completes.

Function
REQ-012 Report SHALL be 19 ASCII bytes, in order: "YY-MM-DD HH:MM:SS" then 0x0D, 0x0A; high nibble of each BCD field first.
REQ-013 Each BCD nibble SHALL map to 0x30+nibble; nibble > 9 SHALL map to 0x3F ('?').
REQ-014 time_now and date_now SHALL be snapshotted in the cycle the report starts; input changes during a report SHALL NOT alter transmitted bytes.
REQ-015 Each byte SHALL be framed as start bit (0), 8 data bits LSB first, one stop bit (1), each bit held exactly BAUD_DIV cycles.
REQ-016 Consecutive bytes of a report SHALL follow back-to-back: next start bit begins in the cycle after the previous stop bit ends; total report length = 190*BAUD_DIV cycles.
REQ-017 State machine SHALL have states IDLE, START, DATA, STOP; IDLE->START on pending request; START->DATA after BAUD_DIV cycles; DATA->STOP after 8th bit; STOP->START if byte index < 18, else STOP->IDLE.
REQ-018 Byte index SHALL count 0..18; bit index 0..7; baud counter 0..BAUD_DIV-1, wrapping to 0 at each bit boundary.
REQ-019 uart_tx SHALL change only at bit boundaries; it SHALL be driven from a register (no combinational glitch).
REQ-020 Request sources: report_req pulse, or (auto_en=1 and time_now[7:0] differs from its value registered the previous cycle).
REQ-021 A request arriving while busy SHALL set a single pending flag; further requests while pending SHALL be merged (at most one queued report).
REQ-022 A pending request SHALL start the next report in the cycle after done; done and busy SHALL NOT be high simultaneously.
REQ-023 A request in the same cycle as done SHALL be queued, not dropped.
REQ-024 The previous-second register SHALL update every cycle regardless of auto_en, so enabling auto_en SHALL NOT trigger a spurious report.
REQ-025 Report start latency SHALL be one cycle: request in cycle N -> busy=1 and uart_tx=0 in cycle N+1 (when idle).

Reset
REQ-026 On rst=1 at a clock edge: uart_tx=1, busy=0, done=0, pending=0, state=IDLE, all counters 0, previous-second register loaded with time_now[7:0].
REQ-027 rst mid-report SHALL abort immediately; line returns high next cycle; no done pulse; queued request discarded.

Verification (CLK_FREQ=1000, BAUD=100, BAUD_DIV=10)
REQ-028 time_now=24'h123456, date_now=32'h25061503, report_req pulse -> line decodes "25-06-15 12:34:56\r\n", done pulse exactly 1900 cycles after busy rises.
REQ-029 time_now=24'h1A3456 -> hour bytes transmitted as 0x31, 0x3F.
REQ-030 auto_en=1, time_now[7:0] steps 0x05->0x06 -> one report with seconds "06"; three further changes during it -> exactly one extra report, starting the cycle after done.
REQ-031 report_req asserted in the done cycle -> second report starts next cycle, back-to-back, no idle bit time.
REQ-032 rst asserted at byte 7 bit 3 -> uart_tx=1, busy=0 next cycle, no done, no further transmission without a new request.
REQ-033 Change time_now during a report -> transmitted bytes match the snapshot taken at start.
